// File: rtl/vga_draw_pkg.sv
// Shared types and defaults for the VGA drawing path blocks.
package vga_draw_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLOT = 2'd1,
        DONE = 2'd2
    } arc_state_t;

    // Octant index 0..7 stands for octants 1..8.
    typedef logic [2:0] octant_t;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

endpackage

// File: rtl/midpoint_step.sv
// One midpoint-circle iteration: next (ox, oy, crit) and the termination flag.
module midpoint_step #(
    parameter int CW = 10,
    parameter int KW = 11
) (
    input  logic signed [CW-1:0] i_ox,
    input  logic signed [CW-1:0] i_oy,
    input  logic signed [KW-1:0] i_crit,
    output logic signed [CW-1:0] o_ox,
    output logic signed [CW-1:0] o_oy,
    output logic signed [KW-1:0] o_crit,
    output logic                 o_term
);

    logic signed [CW-1:0] w_oy1;
    logic signed [CW-1:0] w_ox1;
    logic                 w_keep_x;
    logic signed [KW-1:0] w_delta;

    assign w_oy1    = i_oy + CW'(1);
    assign w_ox1    = i_ox - CW'(1);
    // Sign bit test keeps the "crit <= 0" comparison signed.
    assign w_keep_x = i_crit[KW-1] || (i_crit == '0);

    assign w_delta = w_keep_x
                   ? (KW'(w_oy1) <<< 1) + KW'(1)
                   : ((KW'(w_oy1) - KW'(w_ox1)) <<< 1) + KW'(1);

    assign o_crit = i_crit + w_delta;
    assign o_oy   = w_oy1;
    assign o_ox   = w_keep_x ? i_ox : w_ox1;
    assign o_term = w_oy1 > o_ox;

endmodule

// File: rtl/arc_plotter.sv
// Midpoint-circle arc engine: one octant pixel candidate per clock, masked per octant.
// Optional screen clipping is compiled in with `define CLIP_EN.
module arc_plotter
    import vga_draw_pkg::*;
#(
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int RW       = 8,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [XW-1:0] centre_x,
    input  logic [YW-1:0] centre_y,
    input  logic [RW-1:0] radius,
    input  logic [7:0]    octant_mask,
    input  logic [2:0]    colour,
    output logic          done,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [2:0]    vga_colour,
    output logic          vga_plot
);

    localparam int MXY = (XW > YW) ? XW : YW;
    localparam int CW  = ((MXY > RW) ? MXY : RW) + 2;
    localparam int KW  = RW + 3;

`ifdef CLIP_EN
    localparam bit CLIP_ON = 1'b1;
`else
    localparam bit CLIP_ON = 1'b0;
`endif

    arc_state_t           r_state;
    octant_t              r_oct;
    logic signed [CW-1:0] r_cx;
    logic signed [CW-1:0] r_cy;
    logic signed [CW-1:0] r_ox;
    logic signed [CW-1:0] r_oy;
    logic signed [KW-1:0] r_crit;
    logic [7:0]           r_mask;
    logic [2:0]           r_colour;
    logic                 r_done;
    logic [XW-1:0]        r_vga_x;
    logic [YW-1:0]        r_vga_y;
    logic                 r_vga_plot;

    logic signed [CW-1:0] w_step_ox;
    logic signed [CW-1:0] w_step_oy;
    logic signed [KW-1:0] w_step_crit;
    logic                 w_step_term;

    logic signed [CW-1:0] w_in_cx;
    logic signed [CW-1:0] w_in_cy;
    logic signed [CW-1:0] w_in_r;
    logic signed [KW-1:0] w_in_crit;

    logic signed [CW-1:0] w_sel_cx;
    logic signed [CW-1:0] w_sel_cy;
    logic signed [CW-1:0] w_sel_ox;
    logic signed [CW-1:0] w_sel_oy;
    octant_t              w_sel_oct;
    logic [7:0]           w_sel_mask;
    logic signed [CW-1:0] w_x;
    logic signed [CW-1:0] w_y;
    logic                 w_onscreen;
    logic                 w_plot;

    midpoint_step #(
        .CW (CW),
        .KW (KW)
    ) u_step (
        .i_ox   (r_ox),
        .i_oy   (r_oy),
        .i_crit (r_crit),
        .o_ox   (w_step_ox),
        .o_oy   (w_step_oy),
        .o_crit (w_step_crit),
        .o_term (w_step_term)
    );

    assign w_in_cx   = $signed({{(CW-XW){1'b0}}, centre_x});
    assign w_in_cy   = $signed({{(CW-YW){1'b0}}, centre_y});
    assign w_in_r    = $signed({{(CW-RW){1'b0}}, radius});
    assign w_in_crit = KW'(1) - $signed({3'b000, radius});

    // Pick the octant and geometry that the next edge will put on the bus.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_sel_cx   = r_cx;
        w_sel_cy   = r_cy;
        w_sel_ox   = r_ox;
        w_sel_oy   = r_oy;
        w_sel_oct  = octant_t'(r_oct + 3'd1);
        w_sel_mask = r_mask;
        if (r_state == IDLE) begin
            w_sel_cx   = w_in_cx;
            w_sel_cy   = w_in_cy;
            w_sel_ox   = w_in_r;
            w_sel_oy   = '0;
            w_sel_oct  = '0;
            w_sel_mask = octant_mask;
        end else if (r_oct == 3'd7) begin
            w_sel_ox  = w_step_ox;
            w_sel_oy  = w_step_oy;
            w_sel_oct = '0;
        end
    end

    always_comb begin
        w_x = w_sel_cx + w_sel_ox;
        w_y = w_sel_cy + w_sel_oy;
        case (w_sel_oct)
            3'd0: begin w_x = w_sel_cx + w_sel_ox; w_y = w_sel_cy + w_sel_oy; end
            3'd1: begin w_x = w_sel_cx + w_sel_oy; w_y = w_sel_cy + w_sel_ox; end
            3'd2: begin w_x = w_sel_cx - w_sel_oy; w_y = w_sel_cy + w_sel_ox; end
            3'd3: begin w_x = w_sel_cx - w_sel_ox; w_y = w_sel_cy + w_sel_oy; end
            3'd4: begin w_x = w_sel_cx - w_sel_ox; w_y = w_sel_cy - w_sel_oy; end
            3'd5: begin w_x = w_sel_cx - w_sel_oy; w_y = w_sel_cy - w_sel_ox; end
            3'd6: begin w_x = w_sel_cx + w_sel_oy; w_y = w_sel_cy - w_sel_ox; end
            default: begin w_x = w_sel_cx + w_sel_ox; w_y = w_sel_cy - w_sel_oy; end
        endcase
    end

    assign w_onscreen = !w_x[CW-1] && (w_x < CW'(SCREEN_W)) &&
                        !w_y[CW-1] && (w_y < CW'(SCREEN_H));
    assign w_plot     = w_sel_mask[w_sel_oct] && (!CLIP_ON || w_onscreen);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is sampled on the edge.
        if (!rst_n) begin
            r_state    <= IDLE;
            r_oct      <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_ox       <= '0;
            r_oy       <= '0;
            r_crit     <= '0;
            r_mask     <= '0;
            r_colour   <= '0;
            r_done     <= 1'b0;
            r_vga_x    <= '0;
            r_vga_y    <= '0;
            r_vga_plot <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cx       <= w_in_cx;
                        r_cy       <= w_in_cy;
                        r_ox       <= w_in_r;
                        r_oy       <= '0;
                        r_crit     <= w_in_crit;
                        r_mask     <= octant_mask;
                        r_colour   <= colour;
                        r_oct      <= '0;
                        r_vga_x    <= w_x[XW-1:0];
                        r_vga_y    <= w_y[YW-1:0];
                        r_vga_plot <= w_plot;
                        r_state    <= PLOT;
                    end
                end
                PLOT: begin
                    if (r_oct == 3'd7) begin
                        r_ox   <= w_step_ox;
                        r_oy   <= w_step_oy;
                        r_crit <= w_step_crit;
                    end
                    if (r_oct == 3'd7 && w_step_term) begin
                        r_vga_plot <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_oct      <= w_sel_oct;
                        r_vga_x    <= w_x[XW-1:0];
                        r_vga_y    <= w_y[YW-1:0];
                        r_vga_plot <= w_plot;
                    end
                end
                DONE: begin
                    r_vga_plot <= 1'b0;
                    if (!start) begin
                        r_done  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign done       = r_done;
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_colour;
    assign vga_plot   = r_vga_plot;

endmodule

// File: tb/tb_arc_plotter.sv
// Directed, table-driven bench for arc_plotter; builds with or without CLIP_EN.
module tb_arc_plotter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] radius;
    logic [7:0] octant_mask;
    logic [2:0] colour;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    always #5 clk = ~clk;

    arc_plotter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .centre_x    (centre_x),
        .centre_y    (centre_y),
        .radius      (radius),
        .octant_mask (octant_mask),
        .colour      (colour),
        .done        (done),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot)
    );

    typedef struct {
        int cx, cy, r, mask, col;
        int cycles, plots;
        int s0x, s0y, s0p;
        int idx, kx, ky, kp;
        int minx;
    } vec_t;

`ifdef CLIP_EN
    localparam int CLIP_PLOTS = 22;
    localparam int CLIP_K_P   = 0;
`else
    localparam int CLIP_PLOTS = 32;
    localparam int CLIP_K_P   = 1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int smp_x [0:255];
    int smp_y [0:255];
    int smp_p [0:255];
    int smp_c [0:255];
    int got_cycles, got_plots, got_minx;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Launch a draw and sample every cycle until done rises (bounded).
    task automatic run_draw(input int cx, input int cy, input int r, input int mask, input int col);
        centre_x    = 8'(cx);
        centre_y    = 7'(cy);
        radius      = 8'(r);
        octant_mask = 8'(mask);
        colour      = 3'(col);
        start       = 1'b1;
        got_cycles  = 0;
        got_plots   = 0;
        got_minx    = 1 << 30;
        for (int k = 0; k < 1024; k++) begin
            @(posedge clk);
            #1;
            if (done) break;
            if (k < 256) begin
                smp_x[k] = int'(vga_x);
                smp_y[k] = int'(vga_y);
                smp_p[k] = int'(vga_plot);
                smp_c[k] = int'(vga_colour);
            end
            got_cycles++;
            if (vga_plot) begin
                got_plots++;
                if (int'(vga_x) < got_minx) got_minx = int'(vga_x);
            end
        end
        check("done_rise", 32'(done), 32'd1);
    endtask

    vec_t vecs [5];
    int   n;

    initial begin
        vecs[0] = '{80, 60, 1,  8'hFF, 5, 16, 16,         81, 60, 1, 1, 80, 61, 1,        79};
        vecs[1] = '{10, 10, 0,  8'hFF, 3, 8,  8,          10, 10, 1, 7, 10, 10, 1,        10};
        vecs[2] = '{80, 60, 10, 8'h01, 6, 64, 8,          90, 60, 1, 1, 80, 70, 0,        87};
        vecs[3] = '{80, 60, 10, 8'hFF, 2, 64, 64,         90, 60, 1, 7, 90, 60, 1,        70};
        vecs[4] = '{2,  60, 5,  8'hFF, 7, 32, CLIP_PLOTS, 7,  60, 1, 3, 253, 60, CLIP_K_P, 0};

        rst_n       = 1'b0;
        start       = 1'b0;
        centre_x    = '0;
        centre_y    = '0;
        radius      = '0;
        octant_mask = '0;
        colour      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done",   32'(done),       32'd0);
        check("rst_x",      32'(vga_x),      32'd0);
        check("rst_y",      32'(vga_y),      32'd0);
        check("rst_colour", 32'(vga_colour), 32'd0);
        check("rst_plot",   32'(vga_plot),   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_done", 32'(done), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_draw(vecs[i].cx, vecs[i].cy, vecs[i].r, vecs[i].mask, vecs[i].col);
            check($sformatf("v%0d_cycles", i), 32'(got_cycles), 32'(vecs[i].cycles));
            check($sformatf("v%0d_plots", i),  32'(got_plots),  32'(vecs[i].plots));
            check($sformatf("v%0d_minx", i),   32'(got_minx),   32'(vecs[i].minx));
            check($sformatf("v%0d_s0x", i),    32'(smp_x[0]),   32'(vecs[i].s0x));
            check($sformatf("v%0d_s0y", i),    32'(smp_y[0]),   32'(vecs[i].s0y));
            check($sformatf("v%0d_s0p", i),    32'(smp_p[0]),   32'(vecs[i].s0p));
            check($sformatf("v%0d_col", i),    32'(smp_c[0]),   32'(vecs[i].col));
            check($sformatf("v%0d_kx", i),     32'(smp_x[vecs[i].idx]), 32'(vecs[i].kx));
            check($sformatf("v%0d_ky", i),     32'(smp_y[vecs[i].idx]), 32'(vecs[i].ky));
            check($sformatf("v%0d_kp", i),     32'(smp_p[vecs[i].idx]), 32'(vecs[i].kp));
            // start still high: done holds, nothing plots, no redraw
            repeat (3) begin
                @(posedge clk);
                #1;
                check($sformatf("v%0d_hold_done", i), 32'(done),       32'd1);
                check($sformatf("v%0d_hold_plot", i), 32'(vga_plot),   32'd0);
                check($sformatf("v%0d_hold_col", i),  32'(vga_colour), 32'(vecs[i].col));
            end
            start = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_fall", i), 32'(done), 32'd0);
        end

        // Reset mid-draw, then relaunch from the still-high start with new inputs.
        centre_x    = 8'd80;
        centre_y    = 7'd60;
        radius      = 8'd10;
        octant_mask = 8'hFF;
        colour      = 3'd4;
        start       = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("mid_plot_active", 32'(vga_plot), 32'd1);
        rst_n    = 1'b0;
        centre_x = 8'd20;
        centre_y = 7'd30;
        radius   = 8'd1;
        @(posedge clk);
        #1;
        check("mid_rst_done",   32'(done),       32'd0);
        check("mid_rst_x",      32'(vga_x),      32'd0);
        check("mid_rst_y",      32'(vga_y),      32'd0);
        check("mid_rst_colour", 32'(vga_colour), 32'd0);
        check("mid_rst_plot",   32'(vga_plot),   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("relaunch_x",    32'(vga_x),      32'd21);
        check("relaunch_y",    32'(vga_y),      32'd30);
        check("relaunch_plot", 32'(vga_plot),   32'd1);
        check("relaunch_col",  32'(vga_colour), 32'd4);
        n = 1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (done) break;
            n++;
        end
        check("relaunch_done",   32'(done), 32'd1);
        check("relaunch_cycles", 32'(n),    32'd16);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("relaunch_done_fall", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arc_plotter.md
# arc_plotter

Parametrised midpoint-circle arc engine for the VGA drawing path. It walks one circle of given centre and radius and emits one pixel candidate per clock on the vga_x/vga_y/vga_colour/vga_plot bus for each of the 8 octants. A per-octant enable mask selects which octants are plotted, so circle and Reuleaux-style drawers become thin sequencers over this block. Optional screen clipping suppresses off-screen plots.

## Interface
- XW, default 8: x coordinate width.
- YW, default 7: y coordinate width.
- RW, default 8: radius width.
- SCREEN_W, default 160: visible width in pixels; used only when clipping is compiled in.
- SCREEN_H, default 120: visible height in pixels; used only when clipping is compiled in.
- clk  in  1  sole clock.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- start  in  1  request; level-sensitive, held high until done is seen.
- centre_x  in  XW  circle centre x.
- centre_y  in  YW  circle centre y.
- radius  in  RW  circle radius.
- octant_mask  in  8  bit k-1 enables octant k.
- colour  in  3  pixel colour.
- done  out  1  draw complete.
- vga_x  out  XW  pixel x, low XW bits of computed value.
- vga_y  out  YW  pixel y, low YW bits.
- vga_colour  out  3  latched colour.
- vga_plot  out  1  write strobe.

## Operation
- States: IDLE, PLOT, DONE. A 3-bit octant counter is used in PLOT.
- IDLE, start=1: latch centre, radius, mask and colour. Set ox=radius, oy=0, crit=1-radius. Go to PLOT with octant=1. Inputs are ignored until the block returns to IDLE.
- PLOT: one octant per cycle, in order 1..8. Coordinates per octant:
  - 1 (cx+ox, cy+oy); 2 (cx+oy, cy+ox); 3 (cx-oy, cy+ox); 4 (cx-ox, cy+oy)
  - 5 (cx-ox, cy-oy); 6 (cx-oy, cy-ox); 7 (cx+oy, cy-ox); 8 (cx+ox, cy-oy)
- vga_plot = mask bit for that octant, further gated by clipping when compiled in.
- Masked octants still consume their cycle, so timing is independent of the mask.
- On the octant-8 cycle, advance the step:
  - oy <= oy+1.
  - If crit <= 0: crit += 2*(oy+1)+1.
  - Else: ox <= ox-1 and crit += 2*((oy+1)-(ox-1))+1.
- After the step, if the new oy > new ox, go to DONE. Otherwise return to octant 1.
- Arithmetic: coordinates are signed, max(XW,YW,RW)+2 bits. crit is signed, RW+3 bits.
- DONE: done=1 and vga_plot=0. When start=0, go to IDLE on the next edge and done returns to 0. If start stays high, remain in DONE; no redraw occurs without a low phase.
- radius=0: one iteration, emitting the centre pixel 8 times.

## Timing
- Reset values: done=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0; state IDLE.
- All outputs are registered.
- The edge that samples start in IDLE also drives octant-1 outputs, so they are visible in the following cycle.
- Total plot cycles = 8 × iterations.
- done rises one cycle after the last octant-8 output cycle.
- vga_colour holds the latched colour through PLOT and DONE.
- Reset mid-draw: the next edge forces IDLE with all outputs at reset values. A start still high then relaunches with the current inputs.

## Configuration
- CLIP_EN defined: vga_plot is forced to 0 when x<0, x>=SCREEN_W, y<0 or y>=SCREEN_H. vga_x and vga_y still show the truncated values.
- CLIP_EN undefined: no suppression; coordinates wrap modulo 2^XW and 2^YW.

## Structure
- Package vga_draw_pkg holds:
  - state enum arc_state_t (IDLE, PLOT, DONE);
  - octant index typedef;
  - default SCREEN_W and SCREEN_H constants.
- One sub-module, midpoint_step: combinational next (ox, oy, crit) and terminate flag. Its width is set by parameter.

## Test plan
- Reset with start=0 -> all outputs 0, done=0. Assert rst_n=0 mid-draw -> next edge: IDLE with outputs 0.
- centre (80,60), r=1, mask 8'hFF -> first two outputs (81,60) and (80,61) with plot=1. 16 plot cycles in total, then done=1.
- r=0, centre (10,10) -> 8 cycles of (10,10) with plot=1, then done.
- centre (80,60), r=10, mask 8'h01 -> plot pulses only on every 8th cycle, all at x >= 80. Total cycle count equals the mask=8'hFF run.
- CLIP_EN, centre (2,60), r=5 -> octant-4 first output has vga_x=253, plot=0. Without CLIP_EN, the same output has plot=1.
- Hold start high after done -> done stays 1 with no new plots. Drop start -> done=0 next cycle. Reassert start -> a fresh draw starts.
